// File: rtl/multi_cursor_renderer.sv
// Multi-cursor overlay renderer: keeps a frame of per-pixel cursor owner IDs and
// redraws the sprite footprints whenever a cursor moves or changes visibility.
module multi_cursor_renderer #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int NUM_CURSORS = 2,
    parameter int SPRITE_SIZE = 8,
    parameter int SHAPE       = 0,
    parameter int COLOR_WIDTH = 8,
    parameter logic [COLOR_WIDTH-1:0] COLOR_NONE = '0,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CURSORS*XW-1:0]          cursor_x,
    input  logic [NUM_CURSORS*YW-1:0]          cursor_y,
    input  logic [NUM_CURSORS-1:0]             cursor_en,
    input  logic [NUM_CURSORS*COLOR_WIDTH-1:0] cursor_color,
    input  logic [XW-1:0]                      request_x,
    input  logic [YW-1:0]                      request_y,
    output logic [COLOR_WIDTH-1:0]             render_color,
    output logic                               busy
);

    localparam int OW   = $clog2(NUM_CURSORS + 1);
    localparam int CW   = (NUM_CURSORS > 1) ? $clog2(NUM_CURSORS) : 1;
    localparam int SW   = (SPRITE_SIZE > 1) ? $clog2(SPRITE_SIZE) : 1;
    localparam int NPIX = WIDTH * HEIGHT;
    localparam int FW   = $clog2(NPIX);
    localparam logic [XW:0]   X_LIM    = (XW+1)'(WIDTH);
    localparam logic [YW:0]   Y_LIM    = (YW+1)'(HEIGHT);
    localparam logic [SW-1:0] S_LAST   = SW'(SPRITE_SIZE - 1);
    localparam logic [SW-1:0] S_MID    = SW'(SPRITE_SIZE / 2);
    localparam logic [FW-1:0] LAST_PIX = FW'(NPIX - 1);

    typedef enum logic [2:0] {CLEAR, IDLE, START, ERASE, DRAW} state_t;
    state_t state, state_next;

    logic [OW-1:0]          frame [NPIX];
    logic [XW-1:0]          live_x [NUM_CURSORS];
    logic [YW-1:0]          live_y [NUM_CURSORS];
    logic [XW-1:0]          snap_x [NUM_CURSORS];
    logic [YW-1:0]          snap_y [NUM_CURSORS];
    logic [XW-1:0]          pend_x [NUM_CURSORS];
    logic [YW-1:0]          pend_y [NUM_CURSORS];
    logic [COLOR_WIDTH-1:0] color_q [NUM_CURSORS];
    logic [NUM_CURSORS-1:0] snap_en, pend_en, work_mask, mask_rest;
    logic [NUM_CURSORS-1:0] changed, marked;
    logic [CW-1:0]          cur;
    logic [SW-1:0]          dx, dy;
    logic [FW-1:0]          clr_addr, pix_addr, rd_addr, wr_addr;
    logic [XW:0]            px;
    logic [YW:0]            py;
    logic                   hit, on_screen, last_offset, wr_en, rd_valid;
    logic [OW-1:0]          wr_data, rd_owner;
    logic [COLOR_WIDTH-1:0] owner_color;

    // Change detection, and the cursor currently being walked (lowest pending bit).
    always_comb begin
        cur = '0;
        for (int k = 0; k < NUM_CURSORS; k++) begin
            live_x[k]  = cursor_x[k*XW +: XW];
            live_y[k]  = cursor_y[k*YW +: YW];
            changed[k] = (live_x[k] != snap_x[k]) || (live_y[k] != snap_y[k]) ||
                         (cursor_en[k] != snap_en[k]);
        end
        marked = changed & snap_en;
        for (int k = NUM_CURSORS - 1; k >= 0; k--)
            if (work_mask[k]) cur = CW'(k);
        mask_rest = work_mask & ~(NUM_CURSORS'(1) << cur);
    end

    always_comb begin
        px = (state == ERASE) ? {1'b0, snap_x[cur]} : {1'b0, pend_x[cur]};
        py = (state == ERASE) ? {1'b0, snap_y[cur]} : {1'b0, pend_y[cur]};
        px = px + (XW+1)'(dx);
        py = py + (YW+1)'(dy);
        on_screen   = (px < X_LIM) && (py < Y_LIM);
        pix_addr    = FW'(py) * FW'(WIDTH) + FW'(px);
        last_offset = (dx == S_LAST) && (dy == S_LAST);
        case (SHAPE)
            1:       hit = (dx == '0) || (dx == S_LAST) || (dy == '0) || (dy == S_LAST);
            2:       hit = (dx == S_MID) || (dy == S_MID);
            default: hit = 1'b1;
        endcase
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        wr_addr    = pix_addr;
        wr_data    = '0;
        case (state)
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = clr_addr;
                if (clr_addr == LAST_PIX) state_next = IDLE;
            end
            IDLE: if (|changed) state_next = START;
            START: begin
                if (|marked)         state_next = ERASE;
                else if (|cursor_en) state_next = DRAW;
                else                 state_next = IDLE;
            end
            ERASE: begin
                wr_en = hit && on_screen;
                if (last_offset && mask_rest == '0)
                    state_next = (|pend_en) ? DRAW : IDLE;
            end
            DRAW: begin
                wr_en   = hit && on_screen;
                wr_data = OW'(cur) + OW'(1);
                if (last_offset && mask_rest == '0) state_next = IDLE;
            end
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= CLEAR;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_addr  <= '0;
            dx        <= '0;
            dy        <= '0;
            work_mask <= '0;
            snap_en   <= '0;
            pend_en   <= '0;
            for (int k = 0; k < NUM_CURSORS; k++) begin
                snap_x[k] <= '0;
                snap_y[k] <= '0;
                pend_x[k] <= '0;
                pend_y[k] <= '0;
            end
        end else begin
            case (state)
                CLEAR: clr_addr <= clr_addr + FW'(1);
                START: begin
                    dx      <= '0;
                    dy      <= '0;
                    pend_en <= cursor_en;
                    for (int k = 0; k < NUM_CURSORS; k++) begin
                        pend_x[k] <= live_x[k];
                        pend_y[k] <= live_y[k];
                    end
                    if (|marked) begin
                        work_mask <= marked;
                    end else begin
                        // No erase phase: the snapshot takes the new values right away.
                        work_mask <= cursor_en;
                        snap_en   <= cursor_en;
                        for (int k = 0; k < NUM_CURSORS; k++) begin
                            snap_x[k] <= live_x[k];
                            snap_y[k] <= live_y[k];
                        end
                    end
                end
                ERASE, DRAW: begin
                    if (dx == S_LAST) begin
                        dx <= '0;
                        dy <= (dy == S_LAST) ? '0 : dy + SW'(1);
                    end else begin
                        dx <= dx + SW'(1);
                    end
                    if (last_offset) begin
                        work_mask <= mask_rest;
                        if (state == ERASE && mask_rest == '0) begin
                            work_mask <= pend_en;
                            snap_en   <= pend_en;
                            snap_x    <= pend_x;
                            snap_y    <= pend_y;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the frame RAM has no reset; the CLEAR sweep initialises it instead.
    always_ff @(posedge clk) begin
        if (wr_en) frame[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CURSORS; k++) begin
            if (reset) color_q[k] <= COLOR_NONE;
            else       color_q[k] <= cursor_color[k*COLOR_WIDTH +: COLOR_WIDTH];
        end
    end

    assign rd_valid = ({1'b0, request_x} < X_LIM) && ({1'b0, request_y} < Y_LIM);
    assign rd_addr  = FW'(request_y) * FW'(WIDTH) + FW'(request_x);

    always_comb begin
        owner_color = COLOR_NONE;
        for (int k = 0; k < NUM_CURSORS; k++)
            if (rd_owner == OW'(k + 1)) owner_color = color_q[k];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_owner     <= '0;
            render_color <= COLOR_NONE;
        end else begin
            rd_owner     <= rd_valid ? frame[rd_addr] : '0;
            render_color <= owner_color;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_multi_cursor_renderer.sv
// Self-checking bench for multi_cursor_renderer: directed scenarios plus random cursor
// updates, checked against a geometric model of the ideal overlay frame.
module tb_multi_cursor_renderer;

    localparam int W = 32, H = 32, N = 2, S = 4, CWID = 8;
    localparam int XW = $clog2(W), YW = $clog2(H);
    localparam logic [7:0] NONE = 8'h00, BLUE = 8'h1F, RED = 8'hE0;

    logic              clk = 1'b0;
    logic              reset;
    logic [N*XW-1:0]   cursor_x;
    logic [N*YW-1:0]   cursor_y;
    logic [N-1:0]      cursor_en;
    logic [N*CWID-1:0] cursor_color;
    logic [XW-1:0]     request_x;
    logic [YW-1:0]     request_y;
    logic [CWID-1:0]   render_color;
    logic              busy;

    int       live_x [N], live_y [N], m_x [N], m_y [N];
    bit       live_en [N], m_en [N];
    logic [7:0] live_col [N];
    int       errors = 0, checks = 0;

    multi_cursor_renderer #(
        .WIDTH(W), .HEIGHT(H), .NUM_CURSORS(N), .SPRITE_SIZE(S), .SHAPE(0),
        .COLOR_WIDTH(CWID), .COLOR_NONE(NONE)
    ) dut (
        .clk(clk), .reset(reset), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .cursor_en(cursor_en), .cursor_color(cursor_color), .request_x(request_x),
        .request_y(request_y), .render_color(render_color), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            cursor_x[k*XW +: XW]       = XW'(live_x[k]);
            cursor_y[k*YW +: YW]       = YW'(live_y[k]);
            cursor_en[k]               = live_en[k];
            cursor_color[k*CWID +: CWID] = live_col[k];
        end
    endtask

    // Expected pass length from the last settled inputs to the live ones (0 = no pass).
    function automatic int pass_len();
        int  marked = 0, enabled = 0;
        bit  any = 0, ch;
        for (int k = 0; k < N; k++) begin
            ch = (live_x[k] != m_x[k]) || (live_y[k] != m_y[k]) || (live_en[k] != m_en[k]);
            if (ch) any = 1;
            if (ch && m_en[k]) marked++;
            if (live_en[k]) enabled++;
        end
        return any ? 1 + S * S * (marked + enabled) : 0;
    endfunction

    task automatic commit();
        for (int k = 0; k < N; k++) begin
            m_x[k]  = live_x[k];
            m_y[k]  = live_y[k];
            m_en[k] = live_en[k];
        end
    endtask

    // Ideal overlay: highest-index enabled cursor whose square covers the pixel.
    function automatic logic [7:0] exp_color(input int x, input int y);
        int o = 0;
        for (int k = 0; k < N; k++)
            if (m_en[k] && x >= m_x[k] && x < m_x[k] + S && y >= m_y[k] && y < m_y[k] + S)
                o = k + 1;
        return (o == 0) ? NONE : live_col[o-1];
    endfunction

    task automatic read_pixel(input int x, input int y, output logic [7:0] c);
        request_x = XW'(x);
        request_y = YW'(y);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        c = render_color;
    endtask

    task automatic spot(input string tag, input int x, input int y, input logic [7:0] exp);
        logic [7:0] c;
        read_pixel(x, y, c);
        check(tag, c, exp);
    endtask

    task automatic check_frame(input string tag);
        logic [7:0] c;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                read_pixel(x, y, c);
                check($sformatf("%s(%0d,%0d)", tag, x, y), c, exp_color(x, y));
            end
    endtask

    task automatic wait_pass(input string tag, input int exp_len);
        int n = 0, t = 0;
        while (busy == 1'b0 && t < 8) begin @(negedge clk); t++; end
        while (busy == 1'b1 && n < 5000) begin n++; @(negedge clk); end
        check(tag, n, exp_len);
    endtask

    initial begin
        int n, t, exp1;
        reset     = 1'b1;
        request_x = '0;
        request_y = '0;
        for (int k = 0; k < N; k++) begin
            live_x[k] = 0; live_y[k] = 0; live_en[k] = 0; live_col[k] = NONE;
        end
        commit();
        drive();

        // Reset and clear sweep
        @(negedge clk);
        check("reset_busy", busy, 1);
        check("reset_color", render_color, NONE);
        reset = 1'b0;
        wait_pass("clear_len", W * H);
        spot("clr_0_0", 0, 0, NONE);
        spot("clr_31_31", 31, 31, NONE);

        // First draw
        live_en[0] = 1; live_x[0] = 2; live_y[0] = 3; live_col[0] = BLUE;
        drive();
        wait_pass("draw_len", pass_len());
        commit();
        spot("draw_5_6", 5, 6, BLUE);
        spot("draw_6_6", 6, 6, NONE);
        spot("draw_1_3", 1, 3, NONE);

        // Move
        live_x[0] = 10; live_y[0] = 10;
        drive();
        wait_pass("move_len", pass_len());
        commit();
        spot("move_2_3", 2, 3, NONE);
        spot("move_10_10", 10, 10, BLUE);
        spot("move_13_13", 13, 13, BLUE);

        // Overlap, then disable the upper cursor
        live_en[1] = 1; live_x[1] = 11; live_y[1] = 11; live_col[1] = RED;
        drive();
        wait_pass("overlap_len", pass_len());
        commit();
        spot("overlap_12_12", 12, 12, RED);
        spot("overlap_10_10", 10, 10, BLUE);
        live_en[1] = 0;
        drive();
        wait_pass("disable_len", pass_len());
        commit();
        spot("disable_12_12", 12, 12, BLUE);
        spot("disable_14_14", 14, 14, NONE);

        // Colour-only change, then clipping at the bottom-right corner
        live_col[0] = RED;
        drive();
        wait_pass("color_only_len", 0);
        spot("recolor_10_10", 10, 10, RED);
        live_x[0] = 30; live_y[0] = 30;
        drive();
        wait_pass("clip_len", pass_len());
        commit();
        spot("clip_31_31", 31, 31, RED);
        spot("clip_0_0", 0, 0, NONE);
        spot("clip_1_1", 1, 1, NONE);
        check_frame("frame_clip");

        // Input change during ERASE: pass completes with START values, then re-runs
        live_x[0] = 5; live_y[0] = 5;
        drive();
        exp1 = pass_len();
        commit();
        n = 0; t = 0;
        while (busy == 1'b0 && t < 8) begin @(negedge clk); t++; end
        while (busy == 1'b1 && n < 5000) begin
            n++;
            if (n == 4) begin
                live_x[0] = 20; live_y[0] = 8;
                drive();
            end
            @(negedge clk);
        end
        check("repass_first_len", n, exp1);
        wait_pass("repass_second_len", pass_len());
        commit();
        check_frame("frame_repass");

        // Reset in the middle of DRAW
        live_en[1] = 1; live_x[1] = 0; live_y[1] = 0; live_x[0] = 9;
        drive();
        repeat (25) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        for (int k = 0; k < N; k++) begin
            live_x[k] = 0; live_y[k] = 0; live_en[k] = 0;
        end
        drive();
        commit();
        @(negedge clk);
        reset = 1'b0;
        wait_pass("reset_clear_len", W * H);
        check_frame("frame_after_reset");

        // Random updates
        for (int it = 0; it < 8; it++) begin
            for (int k = 0; k < N; k++) begin
                live_col[k] = 8'($urandom_range(1, 255));
                if (it % 4 != 3 && $urandom_range(0, 3) != 0) begin
                    live_x[k]  = int'($urandom_range(0, W - 1));
                    live_y[k]  = int'($urandom_range(0, H - 1));
                    live_en[k] = ($urandom_range(0, 3) != 0);
                end
            end
            drive();
            wait_pass($sformatf("rand%0d_len", it), pass_len());
            commit();
            check_frame($sformatf("rand%0d", it));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
